// File: rtl/sub_deparser_pkg.sv
// Shared definitions for the sub-deparser: deparse action field layout, container
// map of the PHV, and FSM state encoding.
package sub_deparser_pkg;

   localparam int OFF_MSB  = 12;
   localparam int OFF_LSB  = 6;
   localparam int TYPE_MSB = 5;
   localparam int TYPE_LSB = 4;
   localparam int IDX_MSB  = 3;
   localparam int IDX_LSB  = 1;
   localparam int VLD_BIT  = 0;

   typedef enum logic [1:0] {
      T_NONE = 2'b00,
      T_16   = 2'b01,
      T_32   = 2'b10,
      T_48   = 2'b11
   } act_type_e;

   localparam int N_C16    = 8;
   localparam int N_C32    = 8;
   localparam int N_C48    = 8;
   localparam int C16_BASE = 0;
   localparam int C32_BASE = 128;
   localparam int C48_BASE = 384;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_WRITE = 2'b01,
      S_OUT   = 2'b10
   } state_e;

   function automatic logic [5:0] type_width(input act_type_e t);
      case (t)
         T_16:    type_width = 6'd16;
         T_32:    type_width = 6'd32;
         T_48:    type_width = 6'd48;
         default: type_width = 6'd0;
      endcase
   endfunction

endpackage

// File: rtl/sub_deparser_if.sv
// Packet-in / header-out handshake bundle between the deparser and its neighbours.
interface sub_deparser_if #(
   parameter int C_PARSE_ACTION_LEN = 13,
   parameter int HDR_FIELD_LEN      = 1024,
   parameter int PHV_LEN            = 768,
   parameter int NUM_ACTIONS        = 10
);
   logic [HDR_FIELD_LEN-1:0]                  pkt_hdr_field;
   logic [PHV_LEN-1:0]                        phv_in;
   logic [NUM_ACTIONS*C_PARSE_ACTION_LEN-1:0] deparse_actions;
   logic                                      in_valid;
   logic                                      in_ready;
   logic [HDR_FIELD_LEN-1:0]                  pkt_hdr_out;
   logic                                      hdr_err_out;
   logic                                      out_valid;
   logic                                      out_ready;

   modport master (
      output pkt_hdr_field, phv_in, deparse_actions, in_valid, out_ready,
      input  in_ready, pkt_hdr_out, hdr_err_out, out_valid
   );

   modport slave (
      input  pkt_hdr_field, phv_in, deparse_actions, in_valid, out_ready,
      output in_ready, pkt_hdr_out, hdr_err_out, out_valid
   );
endinterface

// File: rtl/deparse_write_unit.sv
// Applies one deparse action to a header: copies the low bits of the selected PHV
// container to the byte offset, or flags the action when it would run off the end.
module deparse_write_unit
   import sub_deparser_pkg::*;
#(
   parameter int C_PARSE_ACTION_LEN = 13,
   parameter int HDR_FIELD_LEN      = 1024,
   parameter int PHV_LEN            = 768
) (
   input  logic [HDR_FIELD_LEN-1:0]      hdr_in,
   input  logic [C_PARSE_ACTION_LEN-1:0] action,
   input  logic [PHV_LEN-1:0]            phv,
   output logic [HDR_FIELD_LEN-1:0]      hdr_next,
   output logic                          oor
);
   // Wide enough that offset*8 + 48 never wraps.
   localparam int EW = $clog2(HDR_FIELD_LEN + 48) + 1;

   logic [6:0]               off;
   act_type_e                typ;
   logic [2:0]               idx;
   logic                     vld;
   logic                     active;
   logic [15:0]              src16;
   logic [31:0]              src32;
   logic [47:0]              src48;
   logic [47:0]              src;
   logic [47:0]              mask48;
   logic [9:0]               bit_off;
   logic [EW-1:0]            end_bit;
   logic [HDR_FIELD_LEN-1:0] wmask;
   logic [HDR_FIELD_LEN-1:0] wdata;

   always_comb begin
      off     = action[OFF_MSB:OFF_LSB];
      typ     = act_type_e'(action[TYPE_MSB:TYPE_LSB]);
      idx     = action[IDX_MSB:IDX_LSB];
      vld     = action[VLD_BIT];
      src16   = '0;
      src32   = '0;
      src48   = '0;
      for (int i = 0; i < N_C16; i++)
         if (idx == 3'(i)) src16 = phv[C16_BASE + i*16 +: 16];
      for (int i = 0; i < N_C32; i++)
         if (idx == 3'(i)) src32 = phv[C32_BASE + i*32 +: 32];
      for (int i = 0; i < N_C48; i++)
         if (idx == 3'(i)) src48 = phv[C48_BASE + i*48 +: 48];

      case (typ)
         T_16:    begin src = {32'd0, src16}; mask48 = 48'h0000_0000_FFFF; end
         T_32:    begin src = {16'd0, src32}; mask48 = 48'h0000_FFFF_FFFF; end
         T_48:    begin src = src48;          mask48 = 48'hFFFF_FFFF_FFFF; end
         default: begin src = '0;             mask48 = '0;                 end
      endcase

      bit_off  = {off, 3'b000};
      end_bit  = EW'(bit_off) + EW'(type_width(typ));
      active   = vld && (typ != T_NONE);
      oor      = active && (end_bit > EW'(HDR_FIELD_LEN));
      wmask    = {{(HDR_FIELD_LEN-48){1'b0}}, mask48} << bit_off;
      wdata    = {{(HDR_FIELD_LEN-48){1'b0}}, src & mask48} << bit_off;
      hdr_next = (active && !oor) ? ((hdr_in & ~wmask) | wdata) : hdr_in;
   end

endmodule

// File: rtl/sub_deparser.sv
// Header rebuild engine: captures a packet, applies one deparse action per cycle,
// then presents the rebuilt header under valid/ready.
module sub_deparser
   import sub_deparser_pkg::*;
#(
   parameter int C_PARSE_ACTION_LEN = 13,
   parameter int HDR_FIELD_LEN      = 1024,
   parameter int PHV_LEN            = 768,
   parameter int NUM_ACTIONS        = 10
) (
   input  logic           axis_clk,
   input  logic           aresetn,
   sub_deparser_if.slave  bus
);
   localparam int IDX_W = $clog2(NUM_ACTIONS);
   localparam int ACT_W = NUM_ACTIONS * C_PARSE_ACTION_LEN;

   state_e                          state_q, state_d;
   logic [IDX_W-1:0]                idx_q;
   logic [HDR_FIELD_LEN-1:0]        hdr_q;
   logic [HDR_FIELD_LEN-1:0]        hdr_next;
   logic                            err_q;
   logic                            oor;
   logic [PHV_LEN-1:0]              phv_p0;
   logic [ACT_W-1:0]                actions_p0;
   logic [C_PARSE_ACTION_LEN-1:0]   cur_action;
   logic                            in_ready_c;
   logic                            out_valid_c;
   logic                            last_action;

   assign last_action = (idx_q == IDX_W'(NUM_ACTIONS - 1));

   always_comb begin
      cur_action = '0;
      for (int k = 0; k < NUM_ACTIONS; k++)
         if (idx_q == IDX_W'(k)) cur_action = actions_p0[k*C_PARSE_ACTION_LEN +: C_PARSE_ACTION_LEN];
   end

   deparse_write_unit #(
      .C_PARSE_ACTION_LEN (C_PARSE_ACTION_LEN),
      .HDR_FIELD_LEN      (HDR_FIELD_LEN),
      .PHV_LEN            (PHV_LEN)
   ) u_write (
      .hdr_in   (hdr_q),
      .action   (cur_action),
      .phv      (phv_p0),
      .hdr_next (hdr_next),
      .oor      (oor)
   );

   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) state_d = S_WRITE;
         end
         S_WRITE: begin
            if (last_action) state_d = S_OUT;
         end
         S_OUT: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Capture stage (p0) and in-place header rewrite.
   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         idx_q      <= '0;
         hdr_q      <= '0;
         err_q      <= 1'b0;
         phv_p0     <= '0;
         actions_p0 <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.in_valid) begin
                  hdr_q      <= bus.pkt_hdr_field;
                  phv_p0     <= bus.phv_in;
                  actions_p0 <= bus.deparse_actions;
                  err_q      <= 1'b0;
                  idx_q      <= '0;
               end
            end
            S_WRITE: begin
               hdr_q <= hdr_next;
               if (oor) err_q <= 1'b1;
               idx_q <= idx_q + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.out_valid   = out_valid_c;
   assign bus.pkt_hdr_out = hdr_q;
   assign bus.hdr_err_out = err_q;

endmodule

// File: tb/tb_sub_deparser.sv
// Bench for sub_deparser: table of action vectors with a scoreboard of expected
// headers, plus backpressure and mid-packet reset sequences.
module tb_sub_deparser;
   localparam int NA   = 10;
   localparam int ACTW = NA * 13;

   logic clk = 1'b0;
   logic aresetn = 1'b0;
   always #5 clk = ~clk;

   sub_deparser_if bus ();

   sub_deparser dut (
      .axis_clk (clk),
      .aresetn  (aresetn),
      .bus      (bus)
   );

   typedef struct {
      string           name;
      logic [ACTW-1:0] acts;
      logic [1023:0]   exp_hdr;
      logic            exp_err;
   } vec_t;

   typedef struct {
      logic [1023:0] hdr;
      logic          err;
   } exp_t;

   vec_t          vecs[9];
   exp_t          sb[$];
   logic [767:0]  phv_setup;
   int            checks = 0;
   int            errors = 0;

   function automatic logic [12:0] mk_act(input int off, input int t, input int idx, input bit v);
      logic [6:0] o;
      logic [1:0] ty;
      logic [2:0] ix;
      o  = off[6:0];
      ty = t[1:0];
      ix = idx[2:0];
      return {o, ty, ix, v};
   endfunction

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chkw(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h", nm, act);
         $display("FAIL %s: expected %h", nm, exp);
      end
   endtask

   task automatic scramble_inputs();
      logic [1023:0] r;
      for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
      bus.pkt_hdr_field   = r;
      bus.phv_in          = r[767:0] ^ {24{32'h5A5A_A5A5}};
      bus.deparse_actions = r[ACTW-1:0];
   endtask

   task automatic send(input string nm, input logic [ACTW-1:0] acts,
                       input logic [1023:0] eh, input logic ee, input int hold);
      int   cyc;
      bit   seen;
      exp_t e;
      @(negedge clk);
      chk1({nm, "_in_ready_idle"}, bus.in_ready, 1'b1);
      bus.pkt_hdr_field   = '0;
      bus.phv_in          = phv_setup;
      bus.deparse_actions = acts;
      bus.in_valid        = 1'b1;
      sb.push_back('{hdr: eh, err: ee});
      @(posedge clk);
      #1;
      chk1({nm, "_in_ready_busy"}, bus.in_ready, 1'b0);
      scramble_inputs();
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 30) begin
         @(posedge clk);
         cyc++;
         #1;
         if (bus.out_valid) seen = 1'b1;
      end
      bus.in_valid = 1'b0;
      if (!seen) begin
         chk1({nm, "_out_valid_timeout"}, 1'b0, 1'b1);
         void'(sb.pop_front());
         return;
      end
      chki({nm, "_latency"}, cyc, NA);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk1({nm, "_hold_out_valid"}, bus.out_valid, 1'b1);
         chk1({nm, "_hold_in_ready"}, bus.in_ready, 1'b0);
         chkw({nm, "_hold_hdr"}, bus.pkt_hdr_out, sb[0].hdr);
         chk1({nm, "_hold_err"}, bus.hdr_err_out, sb[0].err);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      e = sb.pop_front();
      chkw({nm, "_hdr"}, bus.pkt_hdr_out, e.hdr);
      chk1({nm, "_err"}, bus.hdr_err_out, e.err);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk1({nm, "_out_valid_drop"}, bus.out_valid, 1'b0);
      chk1({nm, "_in_ready_return"}, bus.in_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      logic [ACTW-1:0] a;
      logic [1023:0]   h;

      bus.pkt_hdr_field   = '0;
      bus.phv_in          = '0;
      bus.deparse_actions = '0;
      bus.in_valid        = 1'b0;
      bus.out_ready       = 1'b0;

      phv_setup = '0;
      for (int i = 0; i < 8; i++) begin
         phv_setup[i*16 +: 16]       = 16'h1100 + 16'(i);
         phv_setup[128 + i*32 +: 32] = 32'h2200_0000 + 32'(i);
         phv_setup[384 + i*48 +: 48] = 48'h3300_0000_0000 + 48'(i);
      end
      phv_setup[2*16 +: 16]       = 16'hBEEF;
      phv_setup[128 + 5*32 +: 32] = 32'h1234_5678;
      phv_setup[384 + 7*48 +: 48] = 48'hA1A2_A3A4_A5A6;

      a = '0; a[0 +: 13] = mk_act(4, 1, 2, 1'b1);
      h = '0; h[47:32] = 16'hBEEF;
      vecs[0] = '{name: "single16", acts: a, exp_hdr: h, exp_err: 1'b0};

      a = '0;
      a[0*13 +: 13] = mk_act(0, 3, 7, 1'b1);
      a[1*13 +: 13] = mk_act(10, 2, 5, 1'b1);
      a[2*13 +: 13] = mk_act(20, 1, 2, 1'b1);
      h = '0; h[47:0] = 48'hA1A2_A3A4_A5A6; h[111:80] = 32'h1234_5678; h[175:160] = 16'hBEEF;
      vecs[1] = '{name: "mixed", acts: a, exp_hdr: h, exp_err: 1'b0};

      a = '0;
      a[0*13 +: 13] = mk_act(8, 2, 5, 1'b1);
      a[1*13 +: 13] = mk_act(8, 1, 2, 1'b1);
      h = '0; h[95:64] = 32'h1234_BEEF;
      vecs[2] = '{name: "overlap", acts: a, exp_hdr: h, exp_err: 1'b0};

      a = '0; a[0 +: 13] = mk_act(122, 3, 7, 1'b1);
      h = '0; h[1023:976] = 48'hA1A2_A3A4_A5A6;
      vecs[3] = '{name: "off122_48", acts: a, exp_hdr: h, exp_err: 1'b0};

      a = '0; a[0 +: 13] = mk_act(123, 3, 7, 1'b1);
      vecs[4] = '{name: "off123_48", acts: a, exp_hdr: '0, exp_err: 1'b1};

      a = '0; a[0 +: 13] = mk_act(127, 1, 2, 1'b1);
      vecs[5] = '{name: "off127_16", acts: a, exp_hdr: '0, exp_err: 1'b1};

      a = '0; a[0 +: 13] = mk_act(4, 1, 2, 1'b0);
      vecs[6] = '{name: "invalid_bit", acts: a, exp_hdr: '0, exp_err: 1'b0};

      a = '0; a[0 +: 13] = mk_act(4, 0, 2, 1'b1);
      vecs[7] = '{name: "type_none", acts: a, exp_hdr: '0, exp_err: 1'b0};

      a = '0;
      a[0*13 +: 13] = mk_act(126, 2, 5, 1'b1);
      a[9*13 +: 13] = mk_act(0, 1, 2, 1'b1);
      h = '0; h[15:0] = 16'hBEEF;
      vecs[8] = '{name: "err_then_last", acts: a, exp_hdr: h, exp_err: 1'b1};

      #12;
      chk1("rst_in_ready", bus.in_ready, 1'b1);
      chk1("rst_out_valid", bus.out_valid, 1'b0);
      chk1("rst_err", bus.hdr_err_out, 1'b0);
      chkw("rst_hdr", bus.pkt_hdr_out, '0);
      @(negedge clk);
      aresetn = 1'b1;

      for (int v = 0; v < 9; v++)
         send(vecs[v].name, vecs[v].acts, vecs[v].exp_hdr, vecs[v].exp_err, 0);

      send("backpressure", vecs[1].acts, vecs[1].exp_hdr, vecs[1].exp_err, 5);

      // Reset while the write phase is at action index 4.
      @(negedge clk);
      bus.pkt_hdr_field   = '0;
      bus.phv_in          = phv_setup;
      bus.deparse_actions = vecs[1].acts;
      bus.in_valid        = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk1("midrst_pre_hdr_written", |bus.pkt_hdr_out, 1'b1);
      aresetn = 1'b0;
      #1;
      chkw("midrst_hdr", bus.pkt_hdr_out, '0);
      chk1("midrst_err", bus.hdr_err_out, 1'b0);
      chk1("midrst_out_valid", bus.out_valid, 1'b0);
      chk1("midrst_in_ready", bus.in_ready, 1'b1);
      @(negedge clk);
      aresetn = 1'b1;
      send("after_reset", vecs[0].acts, vecs[0].exp_hdr, vecs[0].exp_err, 0);

      chki("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sub_deparser.md
Name: sub_deparser

Overview:
- Write-back counterpart of the per-field sub-parser.
- Takes a packet header buffer, a PHV of fixed-width containers and a vector of deparse actions, and writes container values back into the header at action-specified byte offsets.
- Applies one action per cycle through a small FSM, then holds the rebuilt header under a valid/ready handshake for the downstream packet merger.

Parameters:
- C_PARSE_ACTION_LEN, 13, width of one deparse action; same encoding as parse actions.
- HDR_FIELD_LEN, 1024, header buffer width in bits.
- PHV_LEN, 768, PHV width: 8x16b + 8x32b + 8x48b containers.
- NUM_ACTIONS, 10, actions per packet.

Ports:
- axis_clk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- pkt_hdr_field  in  HDR_FIELD_LEN  original header bytes.
- phv_in  in  PHV_LEN  containers. 16b idx i at [i*16+:16]; 32b idx i at [128+i*32+:32]; 48b idx i at [384+i*48+:48].
- deparse_actions  in  NUM_ACTIONS*C_PARSE_ACTION_LEN  action k at [k*13+:13].
- in_valid  in  1  inputs valid.
- in_ready  out  1  block can accept.
- pkt_hdr_out  out  HDR_FIELD_LEN  rebuilt header.
- hdr_err_out  out  1  at least one action was out of range for this packet.
- out_valid  out  1  pkt_hdr_out valid.
- out_ready  in  1  downstream accepts.

Behaviour:
- Action encoding:
  - [12:6] byte offset.
  - [5:4] type: 01 = 16b, 10 = 32b, 11 = 48b, 00 = none.
  - [3:1] container index.
  - [0] valid.
  - Destination bits are [offset*8 +: width].
  - Source is the low width bits of the selected container (16b writes take container[15:0]; no sign or zero extension).
- Reset: state IDLE; action index 0; pkt_hdr_out, hdr_err_out, out_valid all 0; in_ready 1 (combinational from IDLE). Internal PHV and action registers cleared.
- FSM:
  - IDLE:
    - in_ready=1.
    - On in_valid: capture header into pkt_hdr_out, capture phv_in and deparse_actions, clear error, index=0, go to WRITE.
  - WRITE:
    - in_ready=0.
    - Each edge applies action[index] to pkt_hdr_out and increments index.
    - When index==NUM_ACTIONS-1, go to OUT.
  - OUT:
    - out_valid=1; pkt_hdr_out and hdr_err_out held stable.
    - On out_ready, go to IDLE and deassert out_valid.
    - in_ready rises the cycle after the output handshake; no same-cycle bypass.
- Latency: out_valid rises NUM_ACTIONS edges after the accepting edge (10 by default). Fixed, independent of action content.
- Skipped actions still consume their cycle:
  - [0]=0 or type 00 leaves the header unchanged and does not set the error flag.
  - Range check: offset*8+width > HDR_FIELD_LEN leaves the header unchanged and sets hdr_err_out sticky for this packet. Example: offset 127 with any width; offset 126 with a 32b write.
- Overlapping writes: actions apply in index order; the later action overwrites shared bytes.
- Input changes after capture are ignored.
- in_valid while not IDLE is ignored; the upstream holds it.
- out_ready without out_valid has no effect.
- Reset mid-operation: the packet is dropped and all state returns to reset values immediately.
- Width arithmetic: offset is 7 bits; compute offset*8+width in at least 11 bits to avoid wrap.

Decomposition:
- Shared package holds:
  - action field positions (OFF_MSB=12, OFF_LSB=6, TYPE_MSB=5, TYPE_LSB=4, IDX_MSB=3, IDX_LSB=1, VLD_BIT=0);
  - type codes (T_NONE, T_16, T_32, T_48);
  - container counts and base offsets (C16_BASE=0, C32_BASE=128, C48_BASE=384);
  - FSM state encoding.
- One combinational sub-module, deparse_write_unit: inputs are the header, one action and the PHV; outputs are the next header and an out-of-range flag. The top-level FSM instantiates it once.

Test Plan:
- Setup for all cases: header all 0x00; PHV 16b container 2 = 0xBEEF, 32b container 5 = 0x12345678, 48b container 7 = 0xA1A2A3A4A5A6.
- Single 16b write: only action 0 = off 4, type 01, idx 2, vld 1; others 0. Expect out_valid 10 cycles after accept, pkt_hdr_out[47:32]=0xBEEF, all other bits 0, hdr_err_out=0.
- Mixed widths: actions 0..2 = (off 0, 48b, idx 7), (off 10, 32b, idx 5), (off 20, 16b, idx 2). Expect header bits [47:0]=0xA1A2A3A4A5A6, [111:80]=0x12345678, [175:160]=0xBEEF.
- Overlap: action 0 = off 8, 32b, idx 5; action 1 = off 8, 16b, idx 2. Expect [95:64]=0x1234BEEF.
- Boundaries:
  - off 122, 48b: [1023:976] written, err=0.
  - off 123, 48b: header unchanged, err=1.
  - off 127, 16b: unchanged, err=1.
  - invalid bit cleared: unchanged, err=0.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles: out_valid and data stable; in_ready=0 throughout; in_ready rises 1 cycle after the out_ready handshake.
  - Separately, assert aresetn low in WRITE at index 4: all outputs 0, next packet processed cleanly.
